// File: rtl/shot_monitor.sv
// shot_monitor: consumer end of the shot-clock interface; scores shots, counts violations, drives a patterned buzzer
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   count      shot-clock value (legal range 0..MAX_COUNT)
//   shoot      shot indication, rising edge is the event
//   buzz       expiry indication, rising edge is the event
//   score      accumulated points, saturating at 255
//   violations violation count, saturating at 255
//   buzzer     patterned buzzer drive (BEEP_NUM beeps of BEEP_LEN on / BEEP_LEN off)
//   seq_err    sticky illegal-count flag
//   busy       high while a beep pattern runs
//   last_shot  clock value at the last scored shot (only with SHOT_MON_LAST_SHOT_EN defined)
module shot_monitor #(
    parameter int MAX_COUNT = 9,
    parameter int SHOT_PTS  = 2,
    parameter int BEEP_NUM  = 3,
    parameter int BEEP_LEN  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] count,
    input  logic       shoot,
    input  logic       buzz,
    output logic [7:0] score,
    output logic [7:0] violations,
    output logic       buzzer,
    output logic       seq_err,
`ifdef SHOT_MON_LAST_SHOT_EN
    output logic       busy,
    output logic [3:0] last_shot
`else
    output logic       busy
`endif
);
    typedef enum logic [1:0] {IDLE, RUN, BEEP_ON, BEEP_OFF} state_t;
    state_t     state;
    logic [3:0] count_q;
    logic       shoot_q, buzz_q, armed;
    logic [7:0] beep_ctr, phase_ctr;
    logic       shoot_evt, buzz_evt, legal;
    logic [8:0] score_sum;
    logic [7:0] viol_inc;
    assign shoot_evt = shoot & ~shoot_q;
    assign buzz_evt  = buzz & ~buzz_q;
    // count_q - 1 is compared in 5 bits so that count_q == 0 never matches a wrapped 15
    assign legal = (count <= 4'(MAX_COUNT)) &&
                   (count == count_q || 5'(count) + 5'd1 == 5'(count_q) ||
                    count == 4'(MAX_COUNT) || (count_q == 4'd0 && count == 4'd0));
    assign score_sum = {1'b0, score} + 9'(SHOT_PTS);
    assign viol_inc  = (violations == 8'hFF) ? violations : violations + 8'd1;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            count_q    <= 4'd0;
            shoot_q    <= 1'b0;
            buzz_q     <= 1'b0;
            armed      <= 1'b0;
            beep_ctr   <= 8'd0;
            phase_ctr  <= 8'd0;
            score      <= 8'd0;
            violations <= 8'd0;
            buzzer     <= 1'b0;
            seq_err    <= 1'b0;
            busy       <= 1'b0;
`ifdef SHOT_MON_LAST_SHOT_EN
            last_shot  <= 4'd0;
`endif
        end else begin
            shoot_q <= shoot;
            buzz_q  <= buzz;
            count_q <= count;
            // the first cycle after reset has no meaningful count_q to compare against
            armed   <= 1'b1;
            if (armed && !legal)
                seq_err <= 1'b1;
            case (state)
                IDLE: if (count == 4'(MAX_COUNT)) state <= RUN;
                RUN: begin
                    if (shoot_evt) begin
                        score <= score_sum[8] ? 8'hFF : score_sum[7:0];
`ifdef SHOT_MON_LAST_SHOT_EN
                        last_shot <= count_q;
`endif
                    end else if (buzz_evt) begin
                        violations <= viol_inc;
                        beep_ctr   <= 8'(BEEP_NUM);
                        phase_ctr  <= 8'(BEEP_LEN - 1);
                        state      <= BEEP_ON;
                        buzzer     <= 1'b1;
                        busy       <= 1'b1;
                    end
                end
                BEEP_ON: begin
                    if (buzz_evt)
                        violations <= viol_inc;
                    if (phase_ctr == 8'd0) begin
                        phase_ctr <= 8'(BEEP_LEN - 1);
                        state     <= BEEP_OFF;
                        buzzer    <= 1'b0;
                    end else
                        phase_ctr <= phase_ctr - 8'd1;
                end
                BEEP_OFF: begin
                    if (buzz_evt)
                        violations <= viol_inc;
                    if (phase_ctr == 8'd0) begin
                        beep_ctr  <= beep_ctr - 8'd1;
                        phase_ctr <= 8'(BEEP_LEN - 1);
                        if (beep_ctr == 8'd1) begin
                            state <= RUN;
                            busy  <= 1'b0;
                        end else begin
                            state  <= BEEP_ON;
                            buzzer <= 1'b1;
                        end
                    end else
                        phase_ctr <= phase_ctr - 8'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_shot_monitor.sv
// tb_shot_monitor: randomized and directed checks of shot_monitor against a behavioural model
module tb_shot_monitor;
    localparam int MAXC = 9;
    localparam int PTS  = 2;
    localparam int NUM  = 3;
    localparam int LEN  = 4;
    localparam int PAT  = NUM * 2 * LEN;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] count = 4'd0;
    logic       shoot = 1'b0;
    logic       buzz = 1'b0;
    logic [7:0] score, violations;
    logic       buzzer, seq_err, busy;
`ifdef SHOT_MON_LAST_SHOT_EN
    logic [3:0] last_shot;
`endif
    int vectors = 0;
    int errs = 0;
    shot_monitor #(.MAX_COUNT(MAXC), .SHOT_PTS(PTS), .BEEP_NUM(NUM), .BEEP_LEN(LEN)) dut (
        .clk(clk), .rst(rst), .count(count), .shoot(shoot), .buzz(buzz),
        .score(score), .violations(violations), .buzzer(buzzer), .seq_err(seq_err),
`ifdef SHOT_MON_LAST_SHOT_EN
        .busy(busy), .last_shot(last_shot)
`else
        .busy(busy)
`endif
    );
    always #5 clk = ~clk;
    // model: mode 0 idle, 1 running, 2 beeping; m_pos = cycles elapsed inside the beep pattern
    int m_mode, m_pos, m_score, m_viol, m_err, m_last, m_cq, m_sq, m_bq, m_armed;
    bit se, be, ok;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mode = 0; m_pos = 0; m_score = 0; m_viol = 0; m_err = 0; m_last = 0;
            m_cq = 0; m_sq = 0; m_bq = 0; m_armed = 0;
        end else begin
            se = shoot && m_sq == 0;
            be = buzz && m_bq == 0;
            ok = int'(count) <= MAXC && (int'(count) == m_cq || int'(count) == m_cq - 1 ||
                 int'(count) == MAXC || (m_cq == 0 && count == 0));
            if (m_armed != 0 && !ok) m_err = 1;
            if (m_mode == 0) begin
                if (int'(count) == MAXC) m_mode = 1;
            end else if (m_mode == 1) begin
                if (se) begin
                    m_score = (m_score + PTS > 255) ? 255 : m_score + PTS;
                    m_last = m_cq;
                end else if (be) begin
                    m_viol = (m_viol < 255) ? m_viol + 1 : 255;
                    m_mode = 2;
                    m_pos = 0;
                end
            end else begin
                if (be) m_viol = (m_viol < 255) ? m_viol + 1 : 255;
                m_pos = m_pos + 1;
                if (m_pos == PAT) m_mode = 1;
            end
            m_sq = int'(shoot); m_bq = int'(buzz); m_cq = int'(count); m_armed = 1;
        end
    end
    function automatic int exp_buzzer();
        return (m_mode == 2 && (m_pos / LEN) % 2 == 0) ? 1 : 0;
    endfunction
    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask
    task automatic lit(input string name, input int act, input int mod, input int exp);
        chk(name, act, exp);
        chk({"model_", name}, mod, exp);
    endtask
    always @(negedge clk) begin
        if (!rst) begin
            chk("score", int'(score), m_score);
            chk("violations", int'(violations), m_viol);
            chk("buzzer", int'(buzzer), exp_buzzer());
            chk("busy", int'(busy), (m_mode == 2) ? 1 : 0);
            chk("seq_err", int'(seq_err), m_err);
`ifdef SHOT_MON_LAST_SHOT_EN
            chk("last_shot", int'(last_shot), m_last);
`endif
        end
    end
    // drive one input vector at a falling edge; returns after the next falling edge
    task automatic cyc(input int c, input bit s, input bit b);
        count = 4'(c);
        shoot = s;
        buzz = b;
        @(negedge clk);
    endtask
    int c;
    bit s, b;
    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;
        cyc(5, 0, 0); cyc(5, 1, 0); cyc(5, 0, 0); cyc(5, 1, 0);
        lit("idle_score", int'(score), m_score, 0);
        cyc(9, 0, 0); cyc(8, 0, 0); cyc(7, 1, 0);
        lit("shot_score", int'(score), m_score, 2);
        lit("shot_buzzer", int'(buzzer), exp_buzzer(), 0);
        lit("shot_seq_err", int'(seq_err), m_err, 0);
        for (int i = 6; i >= 0; i--) cyc(i, 0, 0);
        cyc(0, 0, 1);
        lit("viol_count", int'(violations), m_viol, 1);
        lit("viol_buzzer0", int'(buzzer), exp_buzzer(), 1);
        lit("viol_busy0", int'(busy), (m_mode == 2) ? 1 : 0, 1);
        for (int i = 1; i < PAT; i++) begin
            cyc(0, 0, 0);
            lit("pat_buzzer", int'(buzzer), exp_buzzer(), ((i / LEN) % 2 == 0) ? 1 : 0);
            lit("pat_busy", int'(busy), (m_mode == 2) ? 1 : 0, 1);
        end
        cyc(0, 0, 0);
        lit("pat_end_busy", int'(busy), (m_mode == 2) ? 1 : 0, 0);
        lit("pat_end_buzzer", int'(buzzer), exp_buzzer(), 0);
        cyc(9, 0, 0); cyc(8, 1, 1);
        lit("simul_score", int'(score), m_score, 4);
        lit("simul_viol", int'(violations), m_viol, 1);
        lit("simul_buzzer", int'(buzzer), exp_buzzer(), 0);
        cyc(8, 0, 0);
        repeat (130) begin cyc(8, 1, 0); cyc(8, 0, 0); end
        lit("sat_score", int'(score), m_score, 255);
        for (int i = 7; i >= 3; i--) cyc(i, 0, 0);
        cyc(3, 1, 0);
`ifdef SHOT_MON_LAST_SHOT_EN
        lit("last_shot", int'(last_shot), m_last, 3);
`endif
        cyc(3, 0, 0);
        cyc(9, 0, 0); cyc(8, 0, 0); cyc(7, 0, 0);
        lit("seq_ok", int'(seq_err), m_err, 0);
        cyc(4, 0, 0);
        lit("seq_jump", int'(seq_err), m_err, 1);
        cyc(9, 0, 0);
        lit("seq_sticky", int'(seq_err), m_err, 1);
        cyc(9, 0, 1);
        lit("mid_busy", int'(busy), (m_mode == 2) ? 1 : 0, 1);
        cyc(9, 0, 0); cyc(9, 0, 0);
        #2 rst = 1'b1;
        #1;
        lit("arst_buzzer", int'(buzzer), exp_buzzer(), 0);
        lit("arst_busy", int'(busy), (m_mode == 2) ? 1 : 0, 0);
        lit("arst_score", int'(score), m_score, 0);
        lit("arst_viol", int'(violations), m_viol, 0);
        lit("arst_seq_err", int'(seq_err), m_err, 0);
        @(negedge clk);
        rst = 1'b0;
        cyc(5, 1, 0); cyc(5, 0, 0); cyc(5, 1, 0);
        lit("idle2_score", int'(score), m_score, 0);
        c = 5;
        for (int i = 0; i < 3000; i++) begin
            int r;
            r = int'($urandom_range(0, 999));
            if (r < 5) c = int'($urandom_range(0, 15));
            else if (r < 100) c = MAXC;
            else if (r < 450 && c > 0 && c <= MAXC) c = c - 1;
            s = ($urandom_range(0, 3) == 0) ? ~shoot : shoot;
            b = ($urandom_range(0, 7) == 0) ? ~buzz : buzz;
            if (i % 1000 == 999) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
            cyc(c, s, b);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
